// File: rtl/sdspi_engine.sv
// Byte-level SPI mode-0 master for an SD card: chip-select and speed control
// plus full-duplex byte transfers at a slow init rate or a fast data rate.
module sdspi_engine #(
   parameter int SLOW_DIV = 63,
   parameter int FAST_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] spiOP,
   input  logic [7:0] spiTXD,
   output logic [7:0] spiRXD,
   output logic       spiDONE,
   output logic       spiBUSY,
   input  logic       sdMISO,
   output logic       sdMOSI,
   output logic       sdSCLK,
   output logic       sdCS
);

   // state    | meaning
   // ST_IDLE  | waiting for a command
   // ST_LOW   | sdSCLK low phase, counting down to the rise
   // ST_HIGH  | sdSCLK high phase, counting down to the fall
   // ST_FIN   | one-cycle completion: publish result and strobe done
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   localparam logic [2:0] OP_CSL  = 3'b001;
   localparam logic [2:0] OP_CSH  = 3'b010;
   localparam logic [2:0] OP_FAST = 3'b011;
   localparam logic [2:0] OP_SLOW = 3'b100;
   localparam logic [2:0] OP_XFER = 3'b101;
   localparam logic [2:0] OP_READ = 3'b110;

   localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
   localparam int CW      = (MAX_DIV > 0) ? $clog2(MAX_DIV + 1) : 1;

   localparam logic [CW-1:0] SLOW_RELOAD = CW'(SLOW_DIV);
   localparam logic [CW-1:0] FAST_RELOAD = CW'(FAST_DIV);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [CW-1:0]   reload_q, reload_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      tx_q, tx_d;
   logic [7:0]      rx_q, rx_d;
   logic [7:0]      rxd_q, rxd_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;
   logic            mosi_q, mosi_d;
   logic            sclk_q, sclk_d;
   logic            cs_q, cs_d;
   logic            fast_q, fast_d;
   logic            xfer_q, xfer_d;
   logic [7:0]      load_byte;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         bit_q    <= 3'd0;
         tx_q     <= 8'h00;
         rx_q     <= 8'h00;
         rxd_q    <= 8'h00;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         mosi_q   <= 1'b1;
         sclk_q   <= 1'b0;
         cs_q     <= 1'b1;
         fast_q   <= 1'b0;
         xfer_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         rxd_q    <= rxd_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         mosi_q   <= mosi_d;
         sclk_q   <= sclk_d;
         cs_q     <= cs_d;
         fast_q   <= fast_d;
         xfer_q   <= xfer_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      rxd_d    = rxd_q;
      done_d   = 1'b0;
      busy_d   = busy_q;
      mosi_d   = mosi_q;
      sclk_d   = sclk_q;
      cs_d     = cs_q;
      fast_d   = fast_q;
      xfer_d   = xfer_q;
      load_byte = (spiOP == OP_XFER) ? spiTXD : 8'hFF;

      case (state_q)
         ST_IDLE: begin
            // Control ops take effect at acceptance and finish through ST_FIN
            // so every command gets the same done/busy handshake.
            case (spiOP)
               OP_CSL, OP_CSH, OP_FAST, OP_SLOW: begin
                  if (spiOP == OP_CSL)  cs_d   = 1'b0;
                  if (spiOP == OP_CSH)  cs_d   = 1'b1;
                  if (spiOP == OP_FAST) fast_d = 1'b1;
                  if (spiOP == OP_SLOW) fast_d = 1'b0;
                  busy_d  = 1'b1;
                  xfer_d  = 1'b0;
                  state_d = ST_FIN;
               end
               OP_XFER, OP_READ: begin
                  tx_d     = load_byte;
                  mosi_d   = load_byte[7];
                  reload_d = fast_q ? FAST_RELOAD : SLOW_RELOAD;
                  cnt_d    = fast_q ? FAST_RELOAD : SLOW_RELOAD;
                  bit_d    = 3'd0;
                  busy_d   = 1'b1;
                  xfer_d   = 1'b1;
                  state_d  = ST_LOW;
               end
               default: ;
            endcase
         end

         ST_LOW: begin
            if (cnt_q == '0) begin
               cnt_d   = reload_q;
               sclk_d  = 1'b1;
               rx_d    = {rx_q[6:0], sdMISO};
               state_d = ST_HIGH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_HIGH: begin
            if (cnt_q == '0) begin
               cnt_d  = reload_q;
               sclk_d = 1'b0;
               if (bit_q == 3'd7) begin
                  state_d = ST_FIN;
               end else begin
                  tx_d    = {tx_q[6:0], 1'b0};
                  mosi_d  = tx_q[6];
                  bit_d   = bit_q + 3'd1;
                  state_d = ST_LOW;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_FIN: begin
            if (xfer_q) rxd_d = rx_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            mosi_d  = 1'b1;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign spiRXD  = rxd_q;
   assign spiDONE = done_q;
   assign spiBUSY = busy_q;
   assign sdMOSI  = mosi_q;
   assign sdSCLK  = sclk_q;
   assign sdCS    = cs_q;

endmodule

// File: tb/tb_sdspi_engine.sv
// Directed bench for sdspi_engine: reset values, slow/fast transfers against a
// card model, control-op handshake, busy rejection and mid-transfer reset.
module tb_sdspi_engine;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] spiOP = 3'b000;
   logic [7:0] spiTXD = 8'h00;
   logic [7:0] spiRXD;
   logic       spiDONE;
   logic       spiBUSY;
   logic       sdMISO = 1'b1;
   logic       sdMOSI;
   logic       sdSCLK;
   logic       sdCS;

   int n_tests = 0;
   int n_fail  = 0;

   sdspi_engine #(.SLOW_DIV(63), .FAST_DIV(1)) dut (
      .clk(clk), .reset(reset), .spiOP(spiOP), .spiTXD(spiTXD),
      .spiRXD(spiRXD), .spiDONE(spiDONE), .spiBUSY(spiBUSY),
      .sdMISO(sdMISO), .sdMOSI(sdMOSI), .sdSCLK(sdSCLK), .sdCS(sdCS)
   );

   always #5 clk = ~clk;

   // Runs one transfer from the negedge before acceptance. Observations are
   // taken at each negedge after posedge k (k=0 is the acceptance edge).
   task automatic xfer_run(input logic [2:0] op, input logic [7:0] txd,
                           input logic [7:0] card, input int h, input int inject_k,
                           output int lat, output logic [7:0] mosi_byte,
                           output int bad_len, output int n_done);
      logic prev;
      int   run;
      int   falls;
      lat = -1; mosi_byte = 8'h00; bad_len = 0; n_done = 0;
      run = 0; falls = 0; prev = 1'b0;
      @(negedge clk);
      sdMISO = card[7];
      spiOP  = op;
      spiTXD = txd;
      @(posedge clk);
      for (int k = 0; k < 16 * h + 20; k++) begin
         @(negedge clk);
         spiOP = (k == inject_k) ? 3'b010 : 3'b000;
         if (sdSCLK == prev) begin
            run++;
         end else begin
            if (run != h) bad_len++;
            run = 1;
            if (sdSCLK) begin
               mosi_byte = {mosi_byte[6:0], sdMOSI};
            end else begin
               falls++;
               if (falls <= 7) sdMISO = card[7 - falls];
            end
         end
         prev = sdSCLK;
         if (spiDONE) begin
            n_done++;
            if (lat < 0) lat = k;
         end
      end
      spiOP = 3'b000;
   endtask

   task automatic ctrl_op(input logic [2:0] op);
      @(negedge clk);
      spiOP = op;
      @(negedge clk);
      spiOP = 3'b000;
      @(negedge clk);
   endtask

   int         lat, bad_len, n_done, rises, sclk_hi;
   logic [7:0] mosi_byte;
   logic       prev_sclk;

   initial begin
      // Reset held with random inputs.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         spiOP  = 3'($urandom_range(0, 7));
         spiTXD = 8'($urandom);
         sdMISO = 1'($urandom);
      end
      n_tests++; assert (sdCS === 1'b1) else begin n_fail++; $error("FAIL rst_cs got %b expected 1", sdCS); end
      n_tests++; assert (sdSCLK === 1'b0) else begin n_fail++; $error("FAIL rst_sclk got %b expected 0", sdSCLK); end
      n_tests++; assert (sdMOSI === 1'b1) else begin n_fail++; $error("FAIL rst_mosi got %b expected 1", sdMOSI); end
      n_tests++; assert (spiRXD === 8'h00) else begin n_fail++; $error("FAIL rst_rxd got %h expected 00", spiRXD); end
      n_tests++; assert (spiBUSY === 1'b0) else begin n_fail++; $error("FAIL rst_busy got %b expected 0", spiBUSY); end
      n_tests++; assert (spiDONE === 1'b0) else begin n_fail++; $error("FAIL rst_done got %b expected 0", spiDONE); end
      spiOP = 3'b000;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // CSL then slow XFER A5, card returns 3C.
      ctrl_op(3'b001);
      n_tests++; assert (sdCS === 1'b0) else begin n_fail++; $error("FAIL csl_cs got %b expected 0", sdCS); end
      xfer_run(3'b101, 8'hA5, 8'h3C, 64, -1, lat, mosi_byte, bad_len, n_done);
      n_tests++; assert (mosi_byte === 8'hA5) else begin n_fail++; $error("FAIL slow_mosi got %h expected a5", mosi_byte); end
      n_tests++; assert (bad_len === 0) else begin n_fail++; $error("FAIL slow_halfper got %0d bad levels expected 0", bad_len); end
      n_tests++; assert (lat === 1025) else begin n_fail++; $error("FAIL slow_latency got %0d expected 1025", lat); end
      n_tests++; assert (n_done === 1) else begin n_fail++; $error("FAIL slow_ndone got %0d expected 1", n_done); end
      n_tests++; assert (spiRXD === 8'h3C) else begin n_fail++; $error("FAIL slow_rxd got %h expected 3c", spiRXD); end
      n_tests++; assert (sdCS === 1'b0) else begin n_fail++; $error("FAIL slow_cs got %b expected 0", sdCS); end
      n_tests++; assert (sdMOSI === 1'b1) else begin n_fail++; $error("FAIL slow_mosi_idle got %b expected 1", sdMOSI); end

      // FAST then READ, card returns FE.
      ctrl_op(3'b011);
      xfer_run(3'b110, 8'h00, 8'hFE, 2, -1, lat, mosi_byte, bad_len, n_done);
      n_tests++; assert (mosi_byte === 8'hFF) else begin n_fail++; $error("FAIL read_mosi got %h expected ff", mosi_byte); end
      n_tests++; assert (bad_len === 0) else begin n_fail++; $error("FAIL fast_halfper got %0d bad levels expected 0", bad_len); end
      n_tests++; assert (lat === 33) else begin n_fail++; $error("FAIL fast_latency got %0d expected 33", lat); end
      n_tests++; assert (spiRXD === 8'hFE) else begin n_fail++; $error("FAIL read_rxd got %h expected fe", spiRXD); end

      // Busy rejection: CSH injected mid fast XFER 5A, card returns 81.
      xfer_run(3'b101, 8'h5A, 8'h81, 2, 10, lat, mosi_byte, bad_len, n_done);
      n_tests++; assert (n_done === 1) else begin n_fail++; $error("FAIL busy_ndone got %0d expected 1", n_done); end
      n_tests++; assert (sdCS === 1'b0) else begin n_fail++; $error("FAIL busy_cs got %b expected 0", sdCS); end
      n_tests++; assert (lat === 33) else begin n_fail++; $error("FAIL busy_latency got %0d expected 33", lat); end
      n_tests++; assert (mosi_byte === 8'h5A) else begin n_fail++; $error("FAIL busy_mosi got %h expected 5a", mosi_byte); end
      n_tests++; assert (spiRXD === 8'h81) else begin n_fail++; $error("FAIL busy_rxd got %h expected 81", spiRXD); end

      // CSH, then SLOW back-to-back in the done cycle; no SCLK activity.
      sclk_hi = 0;
      @(negedge clk);
      spiOP = 3'b010;
      @(negedge clk);
      spiOP = 3'b000;
      sclk_hi += int'(sdSCLK);
      n_tests++; assert (spiBUSY === 1'b1) else begin n_fail++; $error("FAIL csh_busy got %b expected 1", spiBUSY); end
      n_tests++; assert (sdCS === 1'b1) else begin n_fail++; $error("FAIL csh_cs got %b expected 1", sdCS); end
      @(negedge clk);
      sclk_hi += int'(sdSCLK);
      n_tests++; assert (spiDONE === 1'b1) else begin n_fail++; $error("FAIL csh_done got %b expected 1", spiDONE); end
      n_tests++; assert (spiBUSY === 1'b0) else begin n_fail++; $error("FAIL csh_busy_done got %b expected 0", spiBUSY); end
      spiOP = 3'b100;
      @(negedge clk);
      spiOP = 3'b000;
      sclk_hi += int'(sdSCLK);
      n_tests++; assert (spiDONE === 1'b0 && spiBUSY === 1'b1) else begin n_fail++; $error("FAIL slow_b2b_accept got done=%b busy=%b expected done=0 busy=1", spiDONE, spiBUSY); end
      @(negedge clk);
      sclk_hi += int'(sdSCLK);
      n_tests++; assert (spiDONE === 1'b1) else begin n_fail++; $error("FAIL slow_b2b_done got %b expected 1", spiDONE); end
      n_tests++; assert (sclk_hi === 0) else begin n_fail++; $error("FAIL ctrl_sclk got %0d high samples expected 0", sclk_hi); end

      // Mid-transfer reset after 3 rises of a slow XFER.
      ctrl_op(3'b001);
      @(negedge clk);
      sdMISO = 1'b0;
      spiOP  = 3'b101;
      spiTXD = 8'h0F;
      @(negedge clk);
      spiOP = 3'b000;
      rises = 0;
      prev_sclk = sdSCLK;
      for (int k = 0; k < 2000 && rises < 3; k++) begin
         @(negedge clk);
         if (sdSCLK && !prev_sclk) rises++;
         prev_sclk = sdSCLK;
      end
      n_tests++; assert (rises === 3) else begin n_fail++; $error("FAIL mid_rises got %0d expected 3", rises); end
      reset = 1'b0;
      #1;
      n_tests++; assert (sdSCLK === 1'b0 && sdCS === 1'b1 && sdMOSI === 1'b1) else begin n_fail++; $error("FAIL mid_rst_pins got sclk=%b cs=%b mosi=%b expected 0 1 1", sdSCLK, sdCS, sdMOSI); end
      n_tests++; assert (spiBUSY === 1'b0 && spiDONE === 1'b0 && spiRXD === 8'h00) else begin n_fail++; $error("FAIL mid_rst_status got busy=%b done=%b rxd=%h expected 0 0 00", spiBUSY, spiDONE, spiRXD); end
      @(negedge clk);
      reset = 1'b1;
      n_done = 0;
      for (int k = 0; k < 1100; k++) begin
         @(negedge clk);
         if (spiDONE) n_done++;
      end
      n_tests++; assert (n_done === 0) else begin n_fail++; $error("FAIL mid_no_done got %0d expected 0", n_done); end
      n_tests++; assert (spiBUSY === 1'b0 && sdSCLK === 1'b0) else begin n_fail++; $error("FAIL mid_idle got busy=%b sclk=%b expected 0 0", spiBUSY, sdSCLK); end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
